// File: rtl/id_scoreboard.sv
// rtl/id_scoreboard.sv - register scoreboard and issue controller for the RV64 decode stage
// Tracks in-flight register writes, blocks RAW/WAW/capacity hazards, retires on writeback.
module id_scoreboard #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int MAX_INFLIGHT = 4,
  parameter int CW           = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            reg1_read_enable,
  input  logic [AW-1:0]   reg1_addr,
  input  logic            reg2_read_enable,
  input  logic [AW-1:0]   reg2_addr,
  input  logic            reg_write_enable,
  input  logic [AW-1:0]   reg_write_addr,
  input  logic            ex_ready,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_addr,
  input  logic            flush,
  output logic            issue_o,
  output logic            stall_o,
  output logic [NREG-1:0] busy_o,
  output logic [CW-1:0]   inflight_o,
  output logic            wb_err_o
);

  // Busy storage covers the full address space so any index is legal; slots
  // at x0 or beyond NREG are held at zero and therefore never report a hazard.
  localparam int NSLOT = 1 << AW;

  logic [NSLOT-1:0] busy;
  logic [CW-1:0]    cnt;
  logic             wb_err;

  logic raw1, raw2, waw, full, hazard;
  logic rd_tracked, set, clr, wb_bad;

  always_comb begin
    raw1       = reg1_read_enable && (reg1_addr != '0) && busy[reg1_addr];
    raw2       = reg2_read_enable && (reg2_addr != '0) && busy[reg2_addr];
    rd_tracked = reg_write_enable && (reg_write_addr != '0);
    waw        = rd_tracked && busy[reg_write_addr];
    full       = rd_tracked && (cnt == CW'(MAX_INFLIGHT));
    hazard     = raw1 || raw2 || waw || full;

    issue_o = id_valid && ex_ready && !hazard && !flush && !rst;
    stall_o = id_valid && (hazard || !ex_ready) && !flush && !rst;

    set    = issue_o && rd_tracked;
    clr    = wb_valid && (wb_addr != '0) && busy[wb_addr];
    wb_bad = wb_valid && (wb_addr != '0) && !busy[wb_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else if (flush) begin
      busy <= '0;
    end else begin
      // set and clr never collide: WAW keeps a busy rd from issuing.
      for (int i = 0; i < NSLOT; i++) begin
        if (i == 0 || i >= NREG)
          busy[i] <= 1'b0;
        else if (set && reg_write_addr == AW'(i))
          busy[i] <= 1'b1;
        else if (clr && wb_addr == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case ({set, clr})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wb_err <= 1'b0;
    else if (flush)
      wb_err <= 1'b0;
    else
      wb_err <= wb_bad;
  end

  assign busy_o     = busy[NREG-1:0];
  assign inflight_o = cnt;
  assign wb_err_o   = wb_err;

endmodule

// File: tb/tb_id_scoreboard.sv
// tb/tb_id_scoreboard.sv - directed self-checking bench for id_scoreboard
module tb_id_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        reg1_read_enable;
  logic [4:0]  reg1_addr;
  logic        reg2_read_enable;
  logic [4:0]  reg2_addr;
  logic        reg_write_enable;
  logic [4:0]  reg_write_addr;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        issue_o;
  logic        stall_o;
  logic [31:0] busy_o;
  logic [2:0]  inflight_o;
  logic        wb_err_o;

  int tests = 0;
  int fails = 0;

  id_scoreboard #(.NREG(32), .AW(5), .MAX_INFLIGHT(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .reg1_read_enable(reg1_read_enable), .reg1_addr(reg1_addr),
    .reg2_read_enable(reg2_read_enable), .reg2_addr(reg2_addr),
    .reg_write_enable(reg_write_enable), .reg_write_addr(reg_write_addr),
    .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .issue_o(issue_o), .stall_o(stall_o), .busy_o(busy_o),
    .inflight_o(inflight_o), .wb_err_o(wb_err_o)
  );

  always #5 clk = ~clk;

  task automatic instr(input logic v, input logic r1e, input logic [4:0] r1,
                       input logic r2e, input logic [4:0] r2,
                       input logic we, input logic [4:0] rd, input logic exr);
    id_valid = v; reg1_read_enable = r1e; reg1_addr = r1;
    reg2_read_enable = r2e; reg2_addr = r2;
    reg_write_enable = we; reg_write_addr = rd; ex_ready = exr;
  endtask

  task automatic wb(input logic v, input logic [4:0] a);
    wb_valid = v; wb_addr = a;
  endtask

  task automatic idle();
    instr(0, 0, 0, 0, 0, 0, 0, 1);
    wb(0, 0);
    flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic issue_write(input logic [4:0] rd);
    instr(1, 1, 0, 0, 0, 1, rd, 1);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    instr(1, 1, 1, 1, 2, 1, 3, 1);
    #1;
    tests++; if (issue_o !== 1'b0) begin fails++; $display("FAIL rst_issue: got %b expected 0", issue_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rst_stall: got %b expected 0", stall_o); end
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL rst_busy: got %h expected 0", busy_o); end
    tests++; if (inflight_o !== 3'd0) begin fails++; $display("FAIL rst_inflight: got %0d expected 0", inflight_o); end
    tests++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL rst_wberr: got %b expected 0", wb_err_o); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (issue_o !== 1'b1) begin fails++; $display("FAIL add_issue: got %b expected 1", issue_o); end
    tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL add_stall: got %b expected 0", stall_o); end
    @(negedge clk);
    idle();
    #1;
    tests++; if (busy_o !== 32'h8) begin fails++; $display("FAIL add_busy: got %h expected 00000008", busy_o); end
    tests++; if (inflight_o !== 3'd1) begin fails++; $display("FAIL add_inflight: got %0d expected 1", inflight_o); end
  endtask

  task automatic test_raw();
    do_reset();
    issue_write(5);
    instr(1, 1, 5, 0, 0, 1, 6, 1);
    #1;
    tests++; if (busy_o !== 32'h20) begin fails++; $display("FAIL raw_busy: got %h expected 00000020", busy_o); end
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) wb(1, 5);
      #1;
      tests++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin
        fails++; $display("FAIL raw_stall_c%0d: got stall=%b issue=%b expected stall=1 issue=0", c, stall_o, issue_o);
      end
      @(negedge clk);
    end
    wb(0, 0);
    #1;
    tests++; if (busy_o !== 32'h0) begin fails++; $display("FAIL raw_busy_clr: got %h expected 0", busy_o); end
    tests++; if (issue_o !== 1'b1) begin fails++; $display("FAIL raw_issue: got %b expected 1", issue_o); end
    @(negedge clk);
    idle();
    #1;
    tests++; if (busy_o !== 32'h40 || inflight_o !== 3'd1) begin
      fails++; $display("FAIL raw_after: got busy=%h inflight=%0d expected busy=00000040 inflight=1", busy_o, inflight_o);
    end
  endtask

  task automatic test_waw_x0();
    do_reset();
    issue_write(7);
    instr(1, 0, 0, 0, 0, 1, 7, 1);
    #1;
    tests++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin
      fails++; $display("FAIL waw_stall: got stall=%b issue=%b expected stall=1 issue=0", stall_o, issue_o);
    end
    instr(1, 1, 8, 0, 0, 1, 9, 0);
    #1;
    tests++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin
      fails++; $display("FAIL exnotready: got stall=%b issue=%b expected stall=1 issue=0", stall_o, issue_o);
    end
    instr(1, 1, 0, 1, 0, 1, 0, 1);
    wb(1, 0);
    #1;
    tests++; if (issue_o !== 1'b1) begin fails++; $display("FAIL x0_issue: got %b expected 1", issue_o); end
    @(negedge clk);
    idle();
    #1;
    tests++; if (inflight_o !== 3'd1 || busy_o !== 32'h80) begin
      fails++; $display("FAIL x0_state: got busy=%h inflight=%0d expected busy=00000080 inflight=1", busy_o, inflight_o);
    end
    tests++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL x0_wberr: got %b expected 0", wb_err_o); end
  endtask

  task automatic test_capacity();
    do_reset();
    for (int r = 1; r <= 4; r++) issue_write(r[4:0]);
    instr(1, 0, 0, 0, 0, 1, 6, 1);
    #1;
    tests++; if (inflight_o !== 3'd4 || busy_o !== 32'h1E) begin
      fails++; $display("FAIL cap_full: got busy=%h inflight=%0d expected busy=0000001e inflight=4", busy_o, inflight_o);
    end
    tests++; if (stall_o !== 1'b1 || issue_o !== 1'b0) begin
      fails++; $display("FAIL cap_stall: got stall=%b issue=%b expected stall=1 issue=0", stall_o, issue_o);
    end
    instr(1, 1, 8, 0, 0, 0, 0, 1);
    #1;
    tests++; if (issue_o !== 1'b1) begin fails++; $display("FAIL cap_nonwriter: got %b expected 1", issue_o); end
    instr(1, 0, 0, 0, 0, 1, 6, 1);
    wb(1, 1);
    @(negedge clk);
    wb(1, 2);
    #1;
    tests++; if (inflight_o !== 3'd3 || busy_o !== 32'h1C) begin
      fails++; $display("FAIL cap_retire: got busy=%h inflight=%0d expected busy=0000001c inflight=3", busy_o, inflight_o);
    end
    tests++; if (issue_o !== 1'b1) begin fails++; $display("FAIL cap_x6_issue: got %b expected 1", issue_o); end
    @(negedge clk);
    idle();
    #1;
    tests++; if (inflight_o !== 3'd3 || busy_o !== 32'h58) begin
      fails++; $display("FAIL cap_setclr: got busy=%h inflight=%0d expected busy=00000058 inflight=3", busy_o, inflight_o);
    end
  endtask

  task automatic test_bad_wb();
    do_reset();
    issue_write(5);
    idle();
    wb(1, 9);
    @(negedge clk);
    wb(0, 0);
    #1;
    tests++; if (wb_err_o !== 1'b1) begin fails++; $display("FAIL badwb_err: got %b expected 1", wb_err_o); end
    tests++; if (busy_o !== 32'h20 || inflight_o !== 3'd1) begin
      fails++; $display("FAIL badwb_state: got busy=%h inflight=%0d expected busy=00000020 inflight=1", busy_o, inflight_o);
    end
    @(negedge clk);
    #1;
    tests++; if (wb_err_o !== 1'b0) begin fails++; $display("FAIL badwb_pulse: got %b expected 0", wb_err_o); end
  endtask

  task automatic test_flush_and_async_reset();
    do_reset();
    issue_write(1); issue_write(2); issue_write(4); issue_write(5);
    instr(1, 1, 8, 0, 0, 0, 0, 1);
    flush = 1'b1;
    #1;
    tests++; if (busy_o !== 32'h36 || inflight_o !== 3'd4) begin
      fails++; $display("FAIL flush_pre: got busy=%h inflight=%0d expected busy=00000036 inflight=4", busy_o, inflight_o);
    end
    tests++; if (issue_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++; $display("FAIL flush_issue: got issue=%b stall=%b expected 0 0", issue_o, stall_o);
    end
    @(negedge clk);
    idle();
    #1;
    tests++; if (busy_o !== 32'h0 || inflight_o !== 3'd0) begin
      fails++; $display("FAIL flush_clr: got busy=%h inflight=%0d expected 0 0", busy_o, inflight_o);
    end
    issue_write(1); issue_write(2); issue_write(4); issue_write(5);
    instr(1, 1, 8, 0, 0, 0, 0, 1);
    #1;
    tests++; if (busy_o !== 32'h36 || inflight_o !== 3'd4) begin
      fails++; $display("FAIL arst_pre: got busy=%h inflight=%0d expected busy=00000036 inflight=4", busy_o, inflight_o);
    end
    rst = 1'b1;
    #1;
    tests++; if (busy_o !== 32'h0 || inflight_o !== 3'd0 || issue_o !== 1'b0 || stall_o !== 1'b0) begin
      fails++; $display("FAIL arst_clr: got busy=%h inflight=%0d issue=%b stall=%b expected all 0", busy_o, inflight_o, issue_o, stall_o);
    end
    #1 rst = 1'b0;
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw_x0();
    test_capacity();
    test_bad_wb();
    test_flush_and_async_reset();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
